// File: rtl/mmio_router.sv
// rtl/mmio_router.sv - table-decoded CPU-to-slave MMIO router with ack/timeout handshake
//
// Purpose: accepts one CPU data-port request at a time, decodes it against
// NSLV base/mask windows, drives a single selected slave until it acknowledges
// or the timeout expires, then returns a one-cycle response pulse. Decode
// misses and timeouts return rsp_err=1 and are counted in a saturating err_cnt.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        CPU request handshake (ready only in IDLE)
//   req_wen/addr/wdata/wstrb   CPU request payload
//   rsp_valid/rsp_rdata/rsp_err one-cycle response, data/err held afterwards
//   slv_sel/slv_ren/slv_wen    one-hot slave select and access strobes
//   common_addr/wdata/wstrb    shared slave request buses
//   slv_rdata/slv_ack          packed slave read data and per-slave acknowledge
//   err_clr/err_cnt            clear and value of the saturating error counter
module mmio_router #(
    parameter int unsigned                NSLV     = 4,
    parameter int unsigned                ADDR_W   = 32,
    parameter int unsigned                DATA_W   = 32,
    parameter logic [NSLV*ADDR_W-1:0]     SLV_BASE = '0,
    parameter logic [NSLV*ADDR_W-1:0]     SLV_MASK = '0,
    parameter int unsigned                TIMEOUT  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_wen,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    input  logic [DATA_W/8-1:0]      req_wstrb,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic [NSLV-1:0]          slv_sel,
    output logic                     slv_ren,
    output logic                     slv_wen,
    output logic [ADDR_W-1:0]        common_addr,
    output logic [DATA_W-1:0]        common_wdata,
    output logic [DATA_W/8-1:0]      common_wstrb,
    input  logic [NSLV*DATA_W-1:0]   slv_rdata,
    input  logic [NSLV-1:0]          slv_ack,
    input  logic                     err_clr,
    output logic [7:0]               err_cnt
);

    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam logic [7:0]  TCNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NSLV-1:0]     sel_q, sel_d;
    logic                ren_q, ren_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [7:0]          tcnt_q, tcnt_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic [NSLV-1:0]     hit_onehot;
    logic [DATA_W-1:0]   sel_rdata;
    logic                ack_sel;

    // Walk from the highest index down so the lowest matching window wins.
    always_comb begin
        hit_onehot = '0;
        for (int i = int'(NSLV) - 1; i >= 0; i--) begin
            if ((req_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
            end
        end
    end

    // sel_q is one-hot, so an OR-mux picks the selected slave's read data.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < int'(NSLV); i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | slv_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ack_sel = |(slv_ack & sel_q);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ren_d       = ren_q;
        wen_d       = wen_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        tcnt_d      = tcnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    tcnt_d  = 8'd0;
                    if (|hit_onehot) begin
                        sel_d   = hit_onehot;
                        ren_d   = ~req_wen;
                        wen_d   = req_wen;
                        state_d = ACCESS;
                    end else begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            ACCESS: begin
                // Ack is checked before the timeout so an ack on the last cycle wins.
                if (ack_sel) begin
                    rsp_rdata_d = ren_q ? sel_rdata : '0;
                    rsp_err_d   = 1'b0;
                    sel_d       = '0;
                    ren_d       = 1'b0;
                    wen_d       = 1'b0;
                    state_d     = RESP;
                end else if (tcnt_q == TCNT_LAST) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    sel_d       = '0;
                    ren_d       = 1'b0;
                    wen_d       = 1'b0;
                    state_d     = RESP;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Clear has priority over a coincident error response.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = 8'd0;
        end else if ((state_q == RESP) && rsp_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            tcnt_q      <= 8'd0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ren_q       <= ren_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            tcnt_q      <= tcnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign rsp_valid    = (state_q == RESP);
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign slv_sel      = sel_q;
    assign slv_ren      = ren_q;
    assign slv_wen      = wen_q;
    assign common_addr  = addr_q;
    assign common_wdata = wdata_q;
    assign common_wstrb = wstrb_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_mmio_router.sv
// tb/tb_mmio_router.sv - self-checking bench for mmio_router
module tb_mmio_router;

    localparam int unsigned NSLV    = 2;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 4;
    localparam logic [NSLV*ADDR_W-1:0] BASE = {32'hBFD0_0000, 32'h0000_0000};
    localparam logic [NSLV*ADDR_W-1:0] MASK = {32'hFFFF_0000, 32'hFFFF_0000};

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [1:0]        slv_sel;
    logic              slv_ren;
    logic              slv_wen;
    logic [31:0]       common_addr;
    logic [31:0]       common_wdata;
    logic [3:0]        common_wstrb;
    logic [63:0]       slv_rdata;
    logic [1:0]        slv_ack;
    logic              err_clr;
    logic [7:0]        err_cnt;

    mmio_router #(
        .NSLV(NSLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .slv_sel(slv_sel), .slv_ren(slv_ren), .slv_wen(slv_wen),
        .common_addr(common_addr), .common_wdata(common_wdata), .common_wstrb(common_wstrb),
        .slv_rdata(slv_rdata), .slv_ack(slv_ack),
        .err_clr(err_clr), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          ack_slv;
        int          ack_after;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  exp_sel;
        int          exp_strobes;
        int          exp_rsp;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];
    int   errors = 0;
    int   checks = 0;
    int   exp_err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          strobes;
        int          rsp_at;
        logic [1:0]  sel_or;
        logic        ren_or;
        logic        wen_or;
        logic        got_err;
        logic [31:0] got_rdata;
        strobes = 0; rsp_at = 0; sel_or = 2'b00; ren_or = 1'b0; wen_or = 1'b0;
        got_err = 1'b0; got_rdata = '0;
        @(negedge clk);
        check($sformatf("v%0d ready", idx), {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr;
        req_wdata = v.wdata; req_wstrb = v.wstrb;
        slv_rdata = {v.rd1, v.rd0};
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = 32'h5555_5555; req_wdata = 32'h0; req_wstrb = 4'h0;
        for (int n = 1; n <= 20 && rsp_at == 0; n++) begin
            slv_ack = (v.ack_after != 0 && n >= v.ack_after) ? (2'b01 << v.ack_slv) : 2'b00;
            @(negedge clk);
            sel_or = sel_or | slv_sel;
            ren_or = ren_or | slv_ren;
            wen_or = wen_or | slv_wen;
            if (slv_ren || slv_wen) begin
                strobes++;
                check($sformatf("v%0d common_addr", idx), common_addr, v.addr);
                check($sformatf("v%0d common_wdata", idx), common_wdata, v.wdata);
                check($sformatf("v%0d common_wstrb", idx), {28'd0, common_wstrb}, {28'd0, v.wstrb});
            end
            if (rsp_valid) begin
                rsp_at    = n;
                got_err   = rsp_err;
                got_rdata = rsp_rdata;
            end
            @(posedge clk);
            #1;
        end
        slv_ack = 2'b00;
        check($sformatf("v%0d sel", idx), {30'd0, sel_or}, {30'd0, v.exp_sel});
        check($sformatf("v%0d ren", idx), {31'd0, ren_or}, {31'd0, (v.exp_strobes > 0) && !v.wen});
        check($sformatf("v%0d wen", idx), {31'd0, wen_or}, {31'd0, (v.exp_strobes > 0) && v.wen});
        check($sformatf("v%0d strobe_cycles", idx), strobes, v.exp_strobes);
        check($sformatf("v%0d rsp_cycle", idx), rsp_at, v.exp_rsp);
        check($sformatf("v%0d rsp_err", idx), {31'd0, got_err}, {31'd0, v.exp_err});
        check($sformatf("v%0d rsp_rdata", idx), got_rdata, v.exp_rdata);
        if (v.exp_err) exp_err_cnt++;
        @(negedge clk);
        check($sformatf("v%0d single_pulse", idx), {31'd0, rsp_valid}, 32'd0);
        check($sformatf("v%0d rdata_hold", idx), rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d err_cnt", idx), {24'd0, err_cnt}, exp_err_cnt);
    endtask

    initial begin
        int pulses;
        int rsp_seen;

        //              wen   addr          wdata         wstrb slv aft rd0           rd1           sel   stb rsp err rdata
        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 0, 1, 32'h1234_5678, 32'hDEAD_BEEF, 2'b01, 1, 2, 1'b0, 32'h1234_5678};
        vecs[1] = '{1'b1, 32'hBFD0_F000, 32'h0000_ABCD, 4'h3, 1, 3, 32'h1111_1111, 32'hCAFE_F00D, 2'b10, 3, 4, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 32'h8000_0000, 32'h0,        4'h0, 0, 0, 32'h2222_2222, 32'h3333_3333, 2'b00, 0, 1, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'hBFD0_0000, 32'h0,        4'h0, 0, 1, 32'h7777_7777, 32'h55AA_55AA, 2'b10, 4, 5, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 32'hBFD0_0004, 32'h0,        4'h0, 1, 4, 32'h4444_4444, 32'h0BAD_F00D, 2'b10, 4, 5, 1'b0, 32'h0BAD_F00D};
        vecs[5] = '{1'b0, 32'h0000_FFFC, 32'h0,        4'h0, 0, 2, 32'hA5A5_0001, 32'h6666_6666, 2'b01, 2, 3, 1'b0, 32'hA5A5_0001};

        rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0; slv_rdata = '0; slv_ack = '0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst req_ready", {31'd0, req_ready}, 32'd1);
        check("rst slv_sel", {30'd0, slv_sel}, 32'd0);
        check("rst strobes", {30'd0, slv_ren, slv_wen}, 32'd0);
        check("rst rsp", {31'd0, rsp_valid}, 32'd0);
        check("rst rsp_rdata_err", rsp_rdata | {31'd0, rsp_err}, 32'd0);
        check("rst common_addr", common_addr, 32'd0);
        check("rst err_cnt", {24'd0, err_cnt}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // Saturation: 256 back-to-back misses, counter must stop at 255.
        pulses = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0000;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            @(negedge clk);
            if (rsp_valid && rsp_err) pulses++;
        end
        @(negedge clk);
        check("sat pulses", pulses, 256);
        check("sat err_cnt", {24'd0, err_cnt}, 32'd255);

        // Clear coincident with a further error response.
        req_valid = 1'b1; req_addr = 32'h8000_0000; err_clr = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("clr rsp_err", {31'd0, rsp_valid & rsp_err}, 32'd1);
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("clr err_cnt", {24'd0, err_cnt}, 32'd0);
        exp_err_cnt = 0;

        // Reset during the second ACCESS cycle.
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h0000_0020;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid sel_before", {30'd0, slv_sel}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid sel_async", {30'd0, slv_sel}, 32'd0);
        check("mid strobes_async", {30'd0, slv_ren, slv_wen}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        check("mid no_rsp", rsp_seen, 0);
        check("mid ready", {31'd0, req_ready}, 32'd1);

        run_vec(vecs[0], 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
